acc_ctrl: RTL and testbench

Sequencer and arbiter for the serial 128-bit accumulator. Two requesters present 32-bit operands in parallel; `acc_ctrl` picks one, drives it MSB-first onto the accumulator's `rx`/`add` serial port, and releases `add` so the accumulator commits the sum. It also scans the accumulator's byte-select port to stream the 128-bit total back as 16 bytes. It is the only master of the accumulator.

---
 rtl/acc_ctrl.sv | 124 ++++++++++++
 tb/tb_acc_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// Sequencer/arbiter for the serial 128-bit accumulator: shifts one granted operand MSB-first, then streams the total back bytewise.
// Define ACC_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module acc_ctrl #(
   parameter int WORD_W = 32,
   parameter int NBYTES = 16
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              rd_req,
   output logic [7:0]        rd_byte,
   output logic              rd_valid,
   output logic              rd_last,
   output logic              busy,
   output logic              acc_rx,
   output logic              acc_add,
   output logic [3:0]        acc_sel,
   input  logic [7:0]        acc_data
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
   localparam logic [3:0]       LAST_BYTE = 4'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, READ} state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bitcnt;
   logic [3:0]        bytecnt;
   logic              gnt0;
   logic              gnt1;
   logic              take;
   logic [WORD_W-1:0] sel_data;

`ifdef ACC_CTRL_RR_EN
   logic prio;  // requester favoured when both are valid

   assign gnt1 = req1_valid & (~req0_valid | prio);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst)
         prio <= 1'b0;
      else if (req0_ready | req1_ready)
         prio <= req0_ready;
   end
`else
   assign gnt1 = req1_valid & ~req0_valid;
`endif

   assign gnt0       = req0_valid & ~gnt1;
   // Readback beats adds, so a pending rd_req suppresses both grants.
   assign take       = (state == IDLE) & ~rd_req;
   assign req0_ready = take & gnt0;
   assign req1_ready = take & gnt1;
   assign sel_data   = gnt1 ? req1_data : req0_data;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state    <= IDLE;
         shreg    <= '0;
         bitcnt   <= '0;
         bytecnt  <= '0;
         acc_add  <= 1'b0;
         acc_rx   <= 1'b0;
         acc_sel  <= '0;
         rd_byte  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         case (state)
            IDLE: begin
               acc_add <= 1'b0;
               acc_rx  <= 1'b0;
               if (rd_req) begin
                  state   <= READ;
                  bytecnt <= '0;
                  acc_sel <= '0;
               end else if (req0_ready | req1_ready) begin
                  // The MSB goes out with the first SHIFT cycle, so only the rest is kept.
                  state   <= SHIFT;
                  shreg   <= {sel_data[WORD_W-2:0], 1'b0};
                  acc_rx  <= sel_data[WORD_W-1];
                  acc_add <= 1'b1;
                  bitcnt  <= '0;
               end
            end
            SHIFT: begin
               if (bitcnt == LAST_BIT) begin
                  state   <= IDLE;
                  acc_add <= 1'b0;
                  acc_rx  <= 1'b0;
               end else begin
                  acc_add <= 1'b1;
                  acc_rx  <= shreg[WORD_W-1];
                  shreg   <= shreg << 1;
                  bitcnt  <= bitcnt + 1'b1;
               end
            end
            READ: begin
               rd_byte  <= acc_data;
               rd_valid <= 1'b1;
               rd_last  <= (bytecnt == LAST_BYTE);
               if (bytecnt == LAST_BYTE) begin
                  state <= IDLE;
               end else begin
                  bytecnt <= bytecnt + 4'd1;
                  acc_sel <= bytecnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl with a behavioural model of the serial accumulator; expected totals are hand-computed constants.
module tb_acc_ctrl;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        req0_valid = 1'b0;
   logic [31:0] req0_data = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [31:0] req1_data = '0;
   logic        req1_ready;
   logic        rd_req = 1'b0;
   logic [7:0]  rd_byte;
   logic        rd_valid;
   logic        rd_last;
   logic        busy;
   logic        acc_rx;
   logic        acc_add;
   logic [3:0]  acc_sel;
   logic [7:0]  acc_data;

   int n_cmp = 0;
   int n_bad = 0;

   acc_ctrl #(.WORD_W(32), .NBYTES(16)) dut (
      .clk(clk), .nRst(nRst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rd_req(rd_req), .rd_byte(rd_byte), .rd_valid(rd_valid), .rd_last(rd_last),
      .busy(busy), .acc_rx(acc_rx), .acc_add(acc_add), .acc_sel(acc_sel),
      .acc_data(acc_data)
   );

   always #5 clk = ~clk;

   // Accumulator: shifts while add is high, commits on the edge after add falls.
   logic [31:0]  m_sr;
   logic [127:0] m_total;
   logic         m_add_d;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         m_sr    <= '0;
         m_total <= '0;
         m_add_d <= 1'b0;
      end else begin
         m_add_d <= acc_add;
         if (acc_add)
            m_sr <= {m_sr[30:0], acc_rx};
         if (m_add_d && !acc_add)
            m_total <= m_total + {96'd0, m_sr};
      end
   end

   assign acc_data = m_total[acc_sel*8 +: 8];

   typedef struct {
      logic         v0;
      logic [31:0]  d0;
      logic         v1;
      logic [31:0]  d1;
      int           g;
      logic [127:0] total;
   } vec_t;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nRst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rd_req = 1'b0;
      tick();
      tick();
      nRst = 1'b1;
      tick();
   endtask

   task automatic wait_grant(output int g);
      g = -1;
      for (int i = 0; i < 120; i++) begin
         #1;
         if (req0_ready) g = 0;
         else if (req1_ready) g = 1;
         if (g >= 0) break;
         tick();
      end
      if (g < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL grant_timeout: got no ready, want a grant");
      end
   endtask

   task automatic finish_word();
      int n;
      n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL word_timeout: got busy=1, want 0");
      end
   endtask

   task automatic readback(output logic [127:0] tot, output int first_at,
                           output int last_at, output int nb);
      tot = '0;
      first_at = -1;
      last_at = -1;
      nb = 0;
      rd_req = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 1) rd_req = 1'b0;
         if (rd_valid) begin
            if (first_at < 0) first_at = c;
            if (nb < 16) tot[nb*8 +: 8] = rd_byte;
            nb++;
         end
         if (rd_last) begin
            last_at = c;
            break;
         end
      end
      if (last_at < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL read_timeout: got no rd_last, want one");
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[6];
      logic [127:0] tot;
      logic [31:0]  seq;
      logic [3:0]   order;
      int g, f, l, nb, cnt, cnt2, gap, bad, idle_cnt;
      logic rdy_seen;

      // Cumulative totals continue from the single-add sequence (total 5).
      tbl[0] = '{1'b0, 32'h0,        1'b1, 32'h0000_0100, 1, 128'h105};
      tbl[1] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,        0, 128'h1_0000_0104};
      tbl[2] = '{1'b0, 32'h0,        1'b1, 32'hFFFF_FFFF, 1, 128'h2_0000_0103};
      tbl[3] = '{1'b1, 32'h8000_0000, 1'b1, 32'h0000_0001, 0, 128'h2_8000_0103};
`ifdef ACC_CTRL_RR_EN
      tbl[4] = '{1'b1, 32'h1,        1'b1, 32'h2,          1, 128'h2_8000_0105};
      tbl[5] = '{1'b1, 32'h10,       1'b1, 32'h20,         0, 128'h2_8000_0115};
`else
      tbl[4] = '{1'b1, 32'h1,        1'b1, 32'h2,          0, 128'h2_8000_0104};
      tbl[5] = '{1'b1, 32'h10,       1'b1, 32'h20,         0, 128'h2_8000_0114};
`endif

      tick();
      tick();
      chk("reset_outputs", {rd_byte, rd_valid, rd_last, busy, acc_rx, acc_add, acc_sel,
                            req0_ready, req1_ready}, 0);
      nRst = 1'b1;
      tick();

      // Single add of 5.
      req0_data = 32'h5;
      req0_valid = 1'b1;
      wait_grant(g);
      chk("single_grant", g, 0);
      tick();
      req0_valid = 1'b0;
      chk("add_after_ready", acc_add, 1);
      cnt = 0;
      seq = '0;
      for (int i = 0; i < 40 && acc_add; i++) begin
         cnt++;
         seq = {seq[30:0], acc_rx};
         tick();
      end
      chk("add_high_cycles", cnt, 32);
      chk("rx_sequence", seq, 32'h5);
      chk("commit_cycle_idle", busy, 0);
      readback(tot, f, l, nb);
      chk("single_total", tot, 128'h5);
      chk("rd_first_latency", f, 2);
      chk("rd_last_latency", l, 17);
      chk("rd_byte_count", nb, 16);
      chk("idle_after_read", busy, 0);
      tick();
      chk("acc_sel_hold", acc_sel, 15);

      for (int i = 0; i < 6; i++) begin
         req0_valid = tbl[i].v0;
         req0_data  = tbl[i].d0;
         req1_valid = tbl[i].v1;
         req1_data  = tbl[i].d1;
         wait_grant(g);
         chk($sformatf("vec%0d_grant", i), g, tbl[i].g);
         tick();
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         finish_word();
         readback(tot, f, l, nb);
         chk($sformatf("vec%0d_total", i), tot, tbl[i].total);
      end

      // Back-to-back 0xFFFF_FFFF from req0.
      do_reset();
      req0_data = 32'hFFFF_FFFF;
      req0_valid = 1'b1;
      wait_grant(g);
      tick();
      cnt = 0;
      for (int i = 0; i < 40 && acc_add; i++) begin
         cnt++;
         tick();
      end
      gap = 0;
      rdy_seen = 1'b0;
      for (int i = 0; i < 5 && !acc_add; i++) begin
         gap++;
         #1;
         if (req0_ready) rdy_seen = 1'b1;
         tick();
      end
      req0_valid = 1'b0;
      cnt2 = 0;
      for (int i = 0; i < 40 && acc_add; i++) begin
         cnt2++;
         tick();
      end
      chk("b2b_first_len", cnt, 32);
      chk("b2b_gap", gap, 1);
      chk("b2b_regrant", rdy_seen, 1);
      chk("b2b_second_len", cnt2, 32);
      readback(tot, f, l, nb);
      chk("b2b_total", tot, 128'h1_FFFF_FFFE);

      // Contention: both valid continuously for 4 grants.
      do_reset();
      req0_data = 32'h1;
      req1_data = 32'h2;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      order = '0;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         order = {order[2:0], g == 1};
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      finish_word();
      readback(tot, f, l, nb);
`ifdef ACC_CTRL_RR_EN
      chk("contend_order", order, 4'b0101);
      chk("contend_total", tot, 128'h6);
`else
      chk("contend_order", order, 4'b0000);
      chk("contend_total", tot, 128'h4);
`endif

      // Read and add requested in the same IDLE cycle.
      do_reset();
      rd_req = 1'b1;
      req1_data = 32'h7;
      req1_valid = 1'b1;
      #1;
      chk("collide_no_ready", req1_ready, 0);
      tick();
      rd_req = 1'b0;
      bad = 0;
      nb = 0;
      tot = '0;
      for (int c = 0; c < 40; c++) begin
         if (rd_valid) begin
            if (nb < 16) tot[nb*8 +: 8] = rd_byte;
            nb++;
         end
         if (rd_last) break;
         if (req1_ready) bad++;
         tick();
      end
      chk("collide_last", rd_last, 1);
      chk("collide_ready_during_read", bad, 0);
      chk("collide_total", tot, 128'h0);
      chk("collide_idle", busy, 0);
      #1;
      chk("collide_ready_after", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      finish_word();

      // Readback requested at SHIFT bit 10.
      req0_data = 32'h10;
      req0_valid = 1'b1;
      wait_grant(g);
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rd_req = 1'b1;
      idle_cnt = 0;
      nb = 0;
      tot = '0;
      for (int c = 0; c < 80; c++) begin
         if (rd_valid) begin
            if (nb < 16) tot[nb*8 +: 8] = rd_byte;
            nb++;
         end
         if (rd_last) begin
            rd_req = 1'b0;
            break;
         end
         if (!busy) idle_cnt++;
         tick();
      end
      rd_req = 1'b0;
      chk("midshift_read_idle", idle_cnt, 1);
      chk("midshift_read_total", tot, 128'h17);

      // Reset at SHIFT bit 16.
      req0_data = 32'h1234;
      req0_valid = 1'b1;
      wait_grant(g);
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      chk("pre_reset_busy", busy, 1);
      nRst = 1'b0;
      #1;
      chk("midshift_reset_outputs", {rd_byte, rd_valid, rd_last, busy, acc_rx, acc_add,
                                     acc_sel, req0_ready, req1_ready}, 0);
      tick();
      nRst = 1'b1;
      tick();
      tick();
      readback(tot, f, l, nb);
      chk("post_reset_total", tot, 128'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
